// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order completion buffer. Allocates a tag for each issued
// instruction, captures results broadcast on the CDB, answers operand-tag
// lookups for the reservation station (with same-cycle CDB bypass) and
// retires finished entries to the register file strictly in program order.
//
// Tag encoding: tag 0 means "no dependency"; entry index i carries tag i+1.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_in       in   asynchronous active-low reset
//   rdy_in       in   global enable; low holds all state, commit_en goes low
//   flush        in   synchronous clear (only while rdy_in is high)
//   issue_en     in   allocate the tail entry
//   issue_rd     in   destination register of the issuing instruction
//   full         out  occupancy equals ROB_SIZE
//   new_tag      out  tag the next issued instruction will receive
//   label1/2     in   operand tags to look up
//   ready1/2     out  operand value available (stored or bypassed)
//   res1/2       out  operand value, 0 when not ready
//   cdb_valid    in   result broadcast valid
//   cdb_tag      in   tag of the broadcast result
//   cdb_val      in   broadcast result value
//   commit_en    out  registered one-cycle retire pulse
//   commit_rd    out  destination register of the retired entry
//   commit_val   out  value of the retired entry
//   commit_tag   out  tag of the retired entry
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_SIZE  = 8,
    parameter int ID_WIDTH  = 4,
    parameter int VAL_WIDTH = 32,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 issue_en,
    input  logic [REG_WIDTH-1:0] issue_rd,
    output logic                 full,
    output logic [ID_WIDTH-1:0]  new_tag,
    input  logic [ID_WIDTH-1:0]  label1,
    input  logic [ID_WIDTH-1:0]  label2,
    output logic                 ready1,
    output logic                 ready2,
    output logic [VAL_WIDTH-1:0] res1,
    output logic [VAL_WIDTH-1:0] res2,
    input  logic                 cdb_valid,
    input  logic [ID_WIDTH-1:0]  cdb_tag,
    input  logic [VAL_WIDTH-1:0] cdb_val,
    output logic                 commit_en,
    output logic [REG_WIDTH-1:0] commit_rd,
    output logic [VAL_WIDTH-1:0] commit_val,
    output logic [ID_WIDTH-1:0]  commit_tag
);

    localparam int PTR_W = $clog2(ROB_SIZE);
    localparam int CNT_W = PTR_W + 1;

    // Entry state. Control bits are reset; payload is only ever read once
    // its entry is done, so it carries no reset.
    logic [ROB_SIZE-1:0]  r_busy;
    logic [ROB_SIZE-1:0]  r_done;
    logic [REG_WIDTH-1:0] r_rd  [ROB_SIZE];
    logic [VAL_WIDTH-1:0] r_val [ROB_SIZE];

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic                 r_commit_en;
    logic [REG_WIDTH-1:0] r_commit_rd;
    logic [VAL_WIDTH-1:0] r_commit_val;
    logic [ID_WIDTH-1:0]  r_commit_tag;

    logic                 w_active;
    logic                 w_issue;
    logic                 w_commit;
    logic                 w_cdb_hit;
    logic [PTR_W-1:0]     w_cdb_idx;
    logic [VAL_WIDTH:0]   w_look1;
    logic [VAL_WIDTH:0]   w_look2;

    // A tag names a real entry only if it is 1..ROB_SIZE.
    function automatic logic tag_ok(input logic [ID_WIDTH-1:0] tag);
        return (tag != '0) && (int'(tag) <= ROB_SIZE);
    endfunction

    function automatic logic [PTR_W-1:0] tag_idx(input logic [ID_WIDTH-1:0] tag);
        logic [ID_WIDTH-1:0] t;
        t = tag - ID_WIDTH'(1);
        return t[PTR_W-1:0];
    endfunction

    // Returns {ready, value}. Stored result wins; otherwise a matching
    // broadcast in the same cycle is forwarded directly.
    function automatic logic [VAL_WIDTH:0] lookup(input logic [ID_WIDTH-1:0] label);
        logic [PTR_W-1:0] idx;
        logic [VAL_WIDTH:0] r;
        r   = '0;
        idx = tag_idx(label);
        if (label == '0) begin
            r = '0;
        end else if (tag_ok(label) && r_busy[idx] && r_done[idx]) begin
            r = {1'b1, r_val[idx]};
        end else if (cdb_valid && (cdb_tag == label)) begin
            r = {1'b1, cdb_val};
        end
        return r;
    endfunction

    assign full    = (r_count == CNT_W'(ROB_SIZE));
    assign new_tag = ID_WIDTH'(r_tail) + ID_WIDTH'(1);

    // Flush and hold both suppress every state-changing action.
    assign w_active  = rdy_in && !flush;
    assign w_issue   = w_active && issue_en && !full;
    assign w_cdb_idx = tag_idx(cdb_tag);
    assign w_cdb_hit = w_active && cdb_valid && tag_ok(cdb_tag) && r_busy[w_cdb_idx];
    // An empty buffer never commits, even if a stale done bit is present.
    assign w_commit  = w_active && (r_count != '0) && r_done[r_head];

    always_comb begin
        w_look1 = lookup(label1);
        w_look2 = lookup(label2);
    end

    assign ready1 = w_look1[VAL_WIDTH];
    assign res1   = w_look1[VAL_WIDTH-1:0];
    assign ready2 = w_look2[VAL_WIDTH];
    assign res2   = w_look2[VAL_WIDTH-1:0];

    assign commit_en  = r_commit_en;
    assign commit_rd  = r_commit_rd;
    assign commit_val = r_commit_val;
    assign commit_tag = r_commit_tag;

    // Control state: pointers, occupancy, busy/done and commit outputs.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_busy       <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_commit_en  <= 1'b0;
            r_commit_rd  <= '0;
            r_commit_val <= '0;
            r_commit_tag <= '0;
        end else if (!rdy_in) begin
            r_commit_en <= 1'b0;
        end else if (flush) begin
            r_busy      <= '0;
            r_done      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_commit_en <= 1'b0;
        end else begin
            r_commit_en <= w_commit;

            if (w_issue) begin
                r_busy[r_tail] <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_tail         <= r_tail + PTR_W'(1);
            end

            if (w_cdb_hit) begin
                r_done[w_cdb_idx] <= 1'b1;
            end

            // Placed after the CDB update so retiring an entry always clears it.
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + PTR_W'(1);
                r_commit_rd    <= r_rd[r_head];
                r_commit_val   <= r_val[r_head];
                r_commit_tag   <= ID_WIDTH'(r_head) + ID_WIDTH'(1);
            end

            case ({w_issue, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd[r_tail] <= issue_rd;
        end
        if (w_cdb_hit) begin
            r_val[w_cdb_idx] <= cdb_val;
        end
    end

endmodule
